// File: rtl/vector_sweep_ctrl.sv
// Sweeps every N_IN-bit vector into two implementations of one function,
// compares their responses after a settle window and records mismatch results.
module vector_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 5,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] resp_a,
  input  logic [N_OUT-1:0] resp_b,
  output logic             busy,
  output logic             mismatch,
  output logic [N_IN:0]    err_count,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             done,
  output logic             pass,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [N_IN-1:0]   vec_n;
  logic [N_IN:0]     err_n;
  logic              ffv_n;
  logic [N_IN-1:0]   ffvec_n;
  logic              mis_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      vec_out          <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
      mismatch         <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      vec_out          <= vec_n;
      err_count        <= err_n;
      first_fail_valid <= ffv_n;
      first_fail_vec   <= ffvec_n;
      mismatch         <= mis_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    vec_n   = vec_out;
    err_n   = err_count;
    ffv_n   = first_fail_valid;
    ffvec_n = first_fail_vec;
    mis_n   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = DRIVE;
          cnt_n   = '0;
          vec_n   = '0;
          err_n   = '0;
          ffv_n   = 1'b0;
          ffvec_n = '0;
        end
      end
      DRIVE: begin
        if (cnt == CNT_LAST) state_n = CHECK;
        else cnt_n = cnt + CW'(1);
      end
      CHECK: begin
        // Case-inequality so X/Z differences on either unit count as failures.
        if (resp_a !== resp_b) begin
          err_n = err_count + (N_IN + 1)'(1);
          mis_n = 1'b1;
          if (!first_fail_valid) begin
            ffv_n   = 1'b1;
            ffvec_n = vec_out;
          end
        end
        if (vec_out == VEC_LAST) begin
          state_n = DONE;
        end else begin
          state_n = DRIVE;
          vec_n   = vec_out + N_IN'(1);
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == DRIVE) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = (state == DONE) && (err_count == '0);
  assign state_dbg = state;

endmodule
